// File: rtl/vend_slot_scheduler.sv
// Round-robin coin-slot scheduler in front of a shared 15c vending core.
// Feeds one coin per transaction, shadows credit and stretches vend/change.
module vend_slot_scheduler #(
    parameter int NUM_SLOTS   = 2,
    parameter int DISP_CYCLES = 4,
    parameter int CNT_W       = 8,
    localparam int OW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int DW = $clog2(DISP_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SLOTS-1:0] slot_valid,
    input  logic [NUM_SLOTS-1:0] slot_coin,
    output logic [NUM_SLOTS-1:0] slot_ready,
    output logic                 core_i,
    output logic                 core_j,
    input  logic                 core_x,
    input  logic                 core_y,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic [1:0]           credit,
    output logic                 dispense,
    output logic                 change_out,
    output logic [CNT_W-1:0]     vend_count,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FEED,
        DISP
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [OW-1:0]        rr_ptr;
    logic [OW-1:0]        grant_idx;
    logic                 grant_any;
    logic [NUM_SLOTS-1:0] ready_c;
    logic                 hs;
    logic                 coin_q;
    logic                 chg_q;
    logic [DW-1:0]        disp_cnt;
    logic [2:0]           sum;
    logic                 pred_x;
    logic                 pred_y;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!grant_any && slot_valid[(int'(rr_ptr) + i) % NUM_SLOTS]) begin
                grant_any = 1'b1;
                grant_idx = OW'((int'(rr_ptr) + i) % NUM_SLOTS);
            end
        end
    end

    assign sum    = {1'b0, credit} + (coin_q ? 3'd2 : 3'd1);
    assign pred_x = (sum >= 3'd3);
    assign pred_y = (sum == 3'd4);

    always_comb begin
        state_n = state;
        ready_c = '0;
        unique case (state)
            IDLE: if (grant_any) ready_c[grant_idx] = 1'b1;
            HOLD: ready_c[owner] = 1'b1;
            FEED: state_n = core_x ? DISP : HOLD;
            DISP: if (disp_cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        hs = |(slot_valid & ready_c);
        if (hs && (state == IDLE || state == HOLD)) state_n = FEED;
    end

    // Ready is forced low while reset is held so no requester sees a grant.
    assign slot_ready = rst ? '0 : ready_c;
    assign core_i     = (state == FEED);
    assign core_j     = (state == FEED) && coin_q;
    assign busy       = (state != IDLE);
    assign dispense   = (state == DISP);
    assign change_out = (state == DISP) && chg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            coin_q     <= 1'b0;
            chg_q      <= 1'b0;
            credit     <= 2'd0;
            disp_cnt   <= '0;
            vend_count <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        owner  <= grant_idx;
                        coin_q <= slot_coin[grant_idx];
                    end
                end
                HOLD: begin
                    if (hs) coin_q <= slot_coin[owner];
                end
                FEED: begin
                    if ({core_x, core_y} != {pred_x, pred_y}) err <= 1'b1;
                    // The core's X is authoritative even when the shadow disagrees.
                    if (core_x) begin
                        credit   <= 2'd0;
                        chg_q    <= core_y;
                        disp_cnt <= DW'(DISP_CYCLES - 1);
                        if (vend_count != '1) vend_count <= vend_count + 1'b1;
                        if (owner == OW'(NUM_SLOTS - 1)) rr_ptr <= '0;
                        else rr_ptr <= owner + 1'b1;
                    end else begin
                        credit <= (sum >= 3'd3) ? 2'd2 : sum[1:0];
                    end
                end
                DISP: begin
                    if (disp_cnt != '0) disp_cnt <= disp_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
